// File: rtl/add_arbiter.sv
// add_arbiter: three requesters share one adder through a round-robin arbiter.
// The winner's operands are latched in IDLE. The sum is registered in CALC.
// The result is held in DONE until the consumer acknowledges it.
module add_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           req,
    input  logic [3*WIDTH-1:0]   op_a,
    input  logic [3*WIDTH-1:0]   op_b,
    output logic [2:0]           gnt,
    output logic                 res_valid,
    input  logic                 res_ack,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic                 overflow,
    output logic [1:0]           res_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         gnt_q;
    logic               res_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               ovf_q;
    logic [1:0]         res_id_q;
    logic [1:0]         id_q;
    logic [1:0]         last_grant_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic               win_vld_d;
    logic [1:0]         win_id_d;
    logic [1:0]         cand;
    logic [WIDTH-1:0]   a_sel_d;
    logic [WIDTH-1:0]   b_sel_d;
    logic [WIDTH:0]     sum_d;

    // Requester index that follows i in the wrap order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Two's-complement overflow: same-sign operands whose sum has a different sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Round-robin search. It starts just after the last granted requester.
    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = 2'd0;
        cand      = next_idx(last_grant_q);
        for (int k = 0; k < 3; k++) begin
            if (!win_vld_d && req[cand]) begin
                win_vld_d = 1'b1;
                win_id_d  = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Route the winning requester's operand lanes to the capture registers.
    always_comb begin
        a_sel_d = op_a[0 +: WIDTH];
        b_sel_d = op_b[0 +: WIDTH];
        case (win_id_d)
            2'd1: begin
                a_sel_d = op_a[WIDTH +: WIDTH];
                b_sel_d = op_b[WIDTH +: WIDTH];
            end
            2'd2: begin
                a_sel_d = op_a[2*WIDTH +: WIDTH];
                b_sel_d = op_b[2*WIDTH +: WIDTH];
            end
            default: begin
                a_sel_d = op_a[0 +: WIDTH];
                b_sel_d = op_b[0 +: WIDTH];
            end
        endcase
    end

    // Shared adder, one bit wider than the operands so the carry-out is kept.
    always_comb begin
        sum_d = {1'b0, a_q} + {1'b0, b_q};
    end

    // Operand capture on a grant. Later input changes cannot reach the in-flight sum.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && win_vld_d) begin
            a_q <= a_sel_d;
            b_q <= b_sel_d;
        end
    end

    // Control FSM with registered grant, result and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_q        <= 3'b000;
            res_valid_q  <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            res_id_q     <= 2'd0;
            id_q         <= 2'd0;
            last_grant_q <= 2'd2;
        end else begin
            case (state_q)
                IDLE: begin
                    gnt_q <= 3'b000;
                    if (win_vld_d) begin
                        gnt_q        <= 3'b001 << win_id_d;
                        id_q         <= win_id_d;
                        last_grant_q <= win_id_d;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    gnt_q       <= 3'b000;
                    result_q    <= sum_d[WIDTH-1:0];
                    carry_q     <= sum_d[WIDTH];
                    ovf_q       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_d[WIDTH-1]);
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    gnt_q <= 3'b000;
                    if (res_ack) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= 3'b000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed testbench for add_arbiter. The expected values are computed by hand.
module tb_add_arbiter;

    localparam int W = 32;

    logic             clk;
    logic             reset;
    logic [2:0]       req;
    logic [3*W-1:0]   op_a;
    logic [3*W-1:0]   op_b;
    logic [2:0]       gnt;
    logic             res_valid;
    logic             res_ack;
    logic [W-1:0]     result;
    logic             carry;
    logic             overflow;
    logic [1:0]       res_id;
    logic             busy;

    int nvec = 0;
    int nerr = 0;

    add_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".gnt"},       {61'd0, gnt},       64'd0);
        check({tag, ".res_valid"}, {63'd0, res_valid}, 64'd0);
        check({tag, ".result"},    {32'd0, result},    64'd0);
        check({tag, ".carry"},     {63'd0, carry},     64'd0);
        check({tag, ".overflow"},  {63'd0, overflow},  64'd0);
        check({tag, ".res_id"},    {62'd0, res_id},    64'd0);
        check({tag, ".busy"},      {63'd0, busy},      64'd0);
    endtask

    logic [W-1:0] rr_a   [3] = '{32'h100, 32'h200, 32'h300};
    logic [W-1:0] rr_b   [3] = '{32'h0,   32'h1,   32'h2};
    logic [W-1:0] rr_sum [3] = '{32'h100, 32'h201, 32'h302};
    int           rr_ord [4] = '{0, 1, 2, 0};

    logic [W-1:0] ar_a   [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE};
    logic [W-1:0] ar_b   [4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'hFFFFFFFD};
    logic [W-1:0] ar_res [4] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFB};
    logic         ar_c   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic         ar_v   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset   = 1'b0;
        req     = 3'b000;
        op_a    = '0;
        op_b    = '0;
        res_ack = 1'b0;

        // Outputs are forced to their reset values before the first clock edge.
        #2;
        check_idle_outputs("rst_async");
        tick();
        tick();
        reset = 1'b1;

        // Single request from requester 1: 5 + 7.
        op_a[1*W +: W] = 32'd5;
        op_b[1*W +: W] = 32'd7;
        req = 3'b010;
        tick();
        check("single.gnt",  {61'd0, gnt},  64'h2);
        check("single.busy", {63'd0, busy}, 64'h1);
        check("single.vld0", {63'd0, res_valid}, 64'h0);
        req = 3'b000;
        tick();
        check("single.gnt_off", {61'd0, gnt},       64'h0);
        check("single.vld",     {63'd0, res_valid}, 64'h1);
        check("single.result",  {32'd0, result},    64'd12);
        check("single.res_id",  {62'd0, res_id},    64'd1);
        check("single.carry",   {63'd0, carry},     64'd0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("single.busy_off", {63'd0, busy},      64'h0);
        check("single.vld_off",  {63'd0, res_valid}, 64'h0);

        // Reset again so that last_grant returns to 2. Then hold all requests with ack high.
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a[i*W +: W] = rr_a[i];
            op_b[i*W +: W] = rr_b[i];
        end
        req     = 3'b111;
        res_ack = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("rr%0d.gnt", n), {61'd0, gnt}, 64'd1 << rr_ord[n]);
            tick();
            check($sformatf("rr%0d.gnt_off", n), {61'd0, gnt},       64'h0);
            check($sformatf("rr%0d.vld", n),     {63'd0, res_valid}, 64'h1);
            check($sformatf("rr%0d.res_id", n),  {62'd0, res_id},    64'(rr_ord[n]));
            check($sformatf("rr%0d.result", n),  {32'd0, result},    {32'd0, rr_sum[rr_ord[n]]});
            tick();
            check($sformatf("rr%0d.idle", n),    {63'd0, busy},      64'h0);
        end
        req     = 3'b000;
        res_ack = 1'b0;

        // Arithmetic boundary cases on requester 1.
        for (int t = 0; t < 4; t++) begin
            op_a[1*W +: W] = ar_a[t];
            op_b[1*W +: W] = ar_b[t];
            req = 3'b010;
            tick();
            check($sformatf("arith%0d.gnt", t), {61'd0, gnt}, 64'h2);
            req = 3'b000;
            tick();
            check($sformatf("arith%0d.result", t), {32'd0, result},   {32'd0, ar_res[t]});
            check($sformatf("arith%0d.carry", t),  {63'd0, carry},    {63'd0, ar_c[t]});
            check($sformatf("arith%0d.ovf", t),    {63'd0, overflow}, {63'd0, ar_v[t]});
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
        end

        // Back-pressure: ack stays low and requester 0 keeps requesting with changing op_a.
        op_a[0 +: W] = 32'd3;
        op_b[0 +: W] = 32'd4;
        req = 3'b001;
        tick();
        check("bp.gnt", {61'd0, gnt}, 64'h1);
        tick();
        check("bp.vld",    {63'd0, res_valid}, 64'h1);
        check("bp.result", {32'd0, result},    64'd7);
        for (int c = 0; c < 10; c++) begin
            op_a[0 +: W] = 32'(c * 17 + 100);
            tick();
            check($sformatf("bp%0d.gnt", c),    {61'd0, gnt},       64'h0);
            check($sformatf("bp%0d.result", c), {32'd0, result},    64'd7);
            check($sformatf("bp%0d.res_id", c), {62'd0, res_id},    64'd0);
            check($sformatf("bp%0d.vld", c),    {63'd0, res_valid}, 64'h1);
        end
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("bp.released", {63'd0, busy}, 64'h0);
        tick();
        check("bp.regrant", {61'd0, gnt}, 64'h1);
        req = 3'b000;
        tick();
        check("bp.regrant_result", {32'd0, result}, {32'd0, 32'(9 * 17 + 100 + 4)});
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;

        // Reset while in CALC: the operation is discarded.
        req = 3'b001;
        tick();
        check("midrst.gnt", {61'd0, gnt}, 64'h1);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("midrst_async");
        tick();
        check("midrst.no_vld", {63'd0, res_valid}, 64'h0);
        req = 3'b100;
        op_a[2*W +: W] = 32'd10;
        op_b[2*W +: W] = 32'd20;
        #2 reset = 1'b1;
        tick();
        check("midrst.first_gnt", {61'd0, gnt}, 64'h4);
        req = 3'b000;
        tick();
        check("midrst.vld",    {63'd0, res_valid}, 64'h1);
        check("midrst.res_id", {62'd0, res_id},    64'd2);
        check("midrst.result", {32'd0, result},    64'd30);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req  input  3  request per requester 0..2, level-sensitive.
REQ-005 op_a  input  3*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 op_b  input  3*WIDTH  operand B; same packing as op_a.
REQ-007 gnt  output  3  one-hot grant pulse; operands of the granted requester captured.
REQ-008 res_valid  output  1  result, carry, overflow and res_id valid.
REQ-009 res_ack  input  1  consumer accepts result while res_valid=1.
REQ-010 result  output  WIDTH  registered sum, op_a + op_b modulo 2^WIDTH.
REQ-011 carry  output  1  unsigned carry-out of the sum.
REQ-012 overflow  output  1  two's-complement signed overflow of the sum.
REQ-013 res_id  output  2  index 0..2 of the requester owning the result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, CALC, DONE; one shared adder, one operation in flight at most.
REQ-016 IDLE: at a rising edge with req != 0, pick the winner, latch its operands and index, drive gnt one-hot for the following cycle only, go to CALC.
REQ-017 IDLE with req == 0: gnt = 0, stay in IDLE.
REQ-018 Arbitration: round-robin; search order starts at (last_grant + 1) mod 3 and wraps 2 -> 0.
REQ-019 last_grant updates only on a grant; after reset last_grant = 2, so requester 0 has first priority.
REQ-020 CALC: at the next edge, register result/carry/overflow from latched operands, set res_valid=1, go to DONE (capture-to-valid latency 1 cycle).
REQ-021 DONE: hold result, carry, overflow, res_id stable while res_ack=0; req ignored, gnt=0.
REQ-022 DONE with res_ack=1 at an edge: clear res_valid, go to IDLE; the next grant occurs no earlier than the following edge (minimum 3 cycles per operation).
REQ-023 res_ack outside DONE has no effect.
REQ-024 Requesters deassert req after seeing gnt; a req still high when IDLE is re-entered is treated as a new request, subject to round-robin.
REQ-025 Operand changes after capture do not affect the in-flight result.
REQ-026 overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]); carry = bit WIDTH of the (WIDTH+1)-bit sum.
REQ-027 Wrap-around: all-ones + 1 gives result 0, carry 1, overflow 0.

Reset
REQ-028 reset=0 immediately forces IDLE, gnt=0, res_valid=0, result=0, carry=0, overflow=0, res_id=0, busy=0, last_grant=2, regardless of clock.
REQ-029 Reset asserted in CALC or DONE discards the in-flight operation; no result is delivered for it.
REQ-030 First grant possible at the first rising edge after reset deasserts.

Verification
REQ-031 Single request: WIDTH=32, req=3'b010, op_a1=5, op_b1=7 -> gnt=010 for 1 cycle, then res_valid=1, result=12, res_id=1, carry=0; ack -> busy=0.
REQ-032 Round-robin: req=3'b111 held, ack in first DONE cycle -> grant order 0,1,2,0, each grant 3 cycles apart.
REQ-033 Arithmetic edges: 0xFFFFFFFF+1 -> result 0, carry 1, overflow 0; 0x7FFFFFFF+1 -> 0x80000000, carry 0, overflow 1; 0x80000000+0x80000000 -> 0, carry 1, overflow 1.
REQ-034 Back-pressure: res_ack low for 10 cycles in DONE with req=3'b001 high and op_a0 changing -> result, res_id stable, gnt=0 throughout.
REQ-035 Reset mid-operation: reset low during CALC -> res_valid stays 0, all outputs 0 asynchronously; after release with req=3'b100, gnt=100 at the first edge.
